mux_scan_nch: RTL and testbench

- Parametrised, registered N-channel multiplexer: the sequential successor to the team's 4:1 mux building block.
- Selects one W-bit channel from NCH packed inputs, in one of two modes:
  - manual: channel index given on sel;
  - scan: round-robin over channels enabled in mask.
- Output is registered, with valid, channel tag, pass-wrap and select-error flags.
- Sits between multi-source datapaths and a single consumer, e.g. time-multiplexed display or readout of lab function outputs.

---
 rtl/mux_scan_nch.sv | 132 +++++++++++++
 tb/tb_mux_scan_nch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nch.sv
// mux_scan_nch: registered N-channel multiplexer with manual and round-robin scan selection.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        packed channel data, channel k at din[k*W +: W]
//   sel        manual channel index (mode = 0)
//   mode       0 = manual, 1 = scan
//   en         capture/advance enable, sampled every rising edge
//   mask       scan participation, bit k enables channel k
//   dout       registered selected data
//   dout_ch    index of the channel currently on dout
//   dout_valid dout/dout_ch were updated by the last edge
//   scan_wrap  last output of a scan pass
//   sel_err    manual sel was out of range (sel >= NCH)
module mux_scan_nch #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 1,
  localparam int unsigned SW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] din,
  input  logic [SW-1:0]    sel,
  input  logic             mode,
  input  logic             en,
  input  logic [NCH-1:0]   mask,
  output logic [W-1:0]     dout,
  output logic [SW-1:0]    dout_ch,
  output logic             dout_valid,
  output logic             scan_wrap,
  output logic             sel_err
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  dout_d;
  logic [SW-1:0] dout_ch_d;
  logic          valid_d, wrap_d, err_d;

  logic          sel_ok;
  logic          hi_found, lo_found, scan_found;
  logic [SW-1:0] hi_idx, lo_idx, scan_idx;
  logic [W-1:0]  sel_data, scan_data;

  // Index following i, wrapping at NCH-1 (also correct for non-power-of-2 NCH).
  function automatic logic [SW-1:0] next_ch(input logic [SW-1:0] i);
    if (32'(i) == NCH - 1) return '0;
    return i + 1'b1;
  endfunction

  assign sel_ok = (32'(sel) < NCH);

  // Circular search split in two halves: the lowest enabled index at or above
  // ptr wins; otherwise the lowest enabled index below ptr (a wrapped pick).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (mask[k]) begin
        if (k >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = SW'(k);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SW'(k);
        end
      end
    end
    scan_found = hi_found | lo_found;
    scan_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Data muxes for the manual and scan picks.
  always_comb begin
    sel_data  = '0;
    scan_data = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (sel == SW'(k))      sel_data  = din[k*W +: W];
      if (scan_idx == SW'(k)) scan_data = din[k*W +: W];
    end
  end

  always_comb begin
    dout_d    = dout;
    dout_ch_d = dout_ch;
    ptr_d     = ptr_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (en) begin
      if (!mode) begin
        if (sel_ok) begin
          dout_d    = sel_data;
          dout_ch_d = sel;
          valid_d   = 1'b1;
          ptr_d     = next_ch(sel);
        end else begin
          // Bad index: blank the data but keep the last good channel tag.
          dout_d = '0;
          err_d  = 1'b1;
        end
      end else if (scan_found) begin
        dout_d    = scan_data;
        dout_ch_d = scan_idx;
        valid_d   = 1'b1;
        wrap_d    = lo_found & ~hi_found | (32'(scan_idx) == NCH - 1);
        ptr_d     = next_ch(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      scan_wrap  <= 1'b0;
      sel_err    <= 1'b0;
      ptr_q      <= '0;
    end else begin
      dout       <= dout_d;
      dout_ch    <= dout_ch_d;
      dout_valid <= valid_d;
      scan_wrap  <= wrap_d;
      sel_err    <= err_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_nch.sv
// tb_mux_scan_nch: scoreboard bench for mux_scan_nch, one 4x8 instance and one 3x4 instance.
module tb_mux_scan_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // NCH = 4, W = 8
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode, en;
  logic [3:0]  mask;
  logic [7:0]  dout;
  logic [1:0]  dout_ch;
  logic        dout_valid, scan_wrap, sel_err;

  // NCH = 3, W = 4
  logic [11:0] din3;
  logic [1:0]  sel3;
  logic        mode3, en3;
  logic [2:0]  mask3;
  logic [3:0]  dout3;
  logic [1:0]  dout_ch3;
  logic        valid3, wrap3, err3;

  mux_scan_nch #(.NCH(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en), .mask(mask),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .scan_wrap(scan_wrap),
    .sel_err(sel_err)
  );

  mux_scan_nch #(.NCH(3), .W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .mode(mode3), .en(en3), .mask(mask3),
    .dout(dout3), .dout_ch(dout_ch3), .dout_valid(valid3), .scan_wrap(wrap3),
    .sel_err(err3)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: 0 = u4, 1 = u3.
  int m_dout[2];
  int m_ch[2];
  int m_ptr[2];

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = 0;
      m_ch[i]   = 0;
      m_ptr[i]  = 0;
    end
  endtask

  function automatic int slice(logic [31:0] d, int k, int w);
    return int'((d >> (k * w)) & ((32'd1 << w) - 1));
  endfunction

  function automatic exp_t model(int id, int n, int w, logic [31:0] d, bit md, bit e, int s,
                                 logic [3:0] mk);
    exp_t r;
    int   i;
    r = '0;
    if (e) begin
      if (!md) begin
        if (s < n) begin
          m_dout[id] = slice(d, s, w);
          m_ch[id]   = s;
          m_ptr[id]  = (s + 1) % n;
          r.valid    = 1'b1;
        end else begin
          m_dout[id] = 0;
          r.err      = 1'b1;
        end
      end else begin
        for (int off = 0; off < n; off++) begin
          i = (m_ptr[id] + off) % n;
          if (mk[i]) begin
            r.valid    = 1'b1;
            r.wrap     = (i < m_ptr[id]) || (i == n - 1);
            m_dout[id] = slice(d, i, w);
            m_ch[id]   = i;
            m_ptr[id]  = (i + 1) % n;
            break;
          end
        end
      end
    end
    r.dout = 8'(m_dout[id]);
    r.ch   = 2'(m_ch[id]);
    return r;
  endfunction

  task automatic drive4(input bit md, input bit e, input int s, input logic [3:0] mk);
    @(negedge clk);
    mode = md; en = e; sel = 2'(s); mask = mk;
    sb.push_back(model(0, 4, 8, din, md, e, s, mk));
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input bit md, input bit e, input int s, input logic [2:0] mk);
    @(negedge clk);
    mode3 = md; en3 = e; sel3 = 2'(s); mask3 = mk;
    sb3.push_back(model(1, 3, 4, {20'b0, din3}, md, e, s, {1'b0, mk}));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t obs, e;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din = $urandom; en = ~en; en3 = ~en3; din3 = 12'($urandom);
      @(posedge clk);
      #1;
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== '0 || {dout3, dout_ch3, valid3, wrap3, err3} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h / %h, want all zero", c, obs,
                 {dout3, dout_ch3, valid3, wrap3, err3});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int c = 0; c < 3; c++) begin
      din = $urandom;
      drive4(1'b0, 1'b0, 1, 4'hF);
      e = sb.pop_front();
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== e || obs !== '0) begin
        n_fail++;
        $display("FAIL reset_release_en0[%0d]: got %h, want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t obs, e;
    din = 32'h0000_00A5;
    drive4(1'b0, 1'b1, 0, 4'h0);
    e = sb.pop_front();
    obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
    n_tests++;
    if (obs !== e || dout !== 8'hA5 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: got %h, want %h", obs, e);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got %h, want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_manual();
    exp_t obs, e;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    drive4(1'b0, 1'b1, 2, 4'h0);
    e = sb.pop_front();
    obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
    n_tests++;
    if (obs !== e || dout !== 8'h33 || dout_ch !== 2'd2 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL manual_sel2: got %h, want %h", obs, e);
    end
    drive4(1'b0, 1'b0, 0, 4'h0);
    e = sb.pop_front();
    obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
    n_tests++;
    if (obs !== e || dout !== 8'h33 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_hold: got %h, want %h", obs, e);
    end
  endtask

  task automatic test_full_scan();
    exp_t obs, e;
    din = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    drive4(1'b0, 1'b1, 3, 4'h0);  // leaves ptr at 0
    void'(sb.pop_front());
    for (int c = 0; c < 5; c++) begin
      drive4(1'b1, 1'b1, 0, 4'hF);
      e = sb.pop_front();
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== e || dout_ch !== 2'(c % 4) || scan_wrap !== (c == 3)) begin
        n_fail++;
        $display("FAIL full_scan[%0d]: got %h, want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_masked_scan();
    exp_t obs, e;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    drive4(1'b0, 1'b1, 3, 4'h0);
    void'(sb.pop_front());
    for (int c = 0; c < 3; c++) begin
      drive4(1'b1, 1'b1, 0, 4'b0100);
      e = sb.pop_front();
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== e || dout_ch !== 2'd2 || dout !== 8'h33 || scan_wrap !== (c > 0)) begin
        n_fail++;
        $display("FAIL masked_scan[%0d]: got %h, want %h", c, obs, e);
      end
    end
    din = 32'hFFFF_FFFF;
    drive4(1'b1, 1'b1, 0, 4'b0000);
    e = sb.pop_front();
    obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
    n_tests++;
    if (obs !== e || dout_valid !== 1'b0 || dout !== 8'h33) begin
      n_fail++;
      $display("FAIL empty_mask: got %h, want %h", obs, e);
    end
  endtask

  task automatic test_mode_switch();
    exp_t obs, e;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    drive4(1'b0, 1'b1, 1, 4'h0);
    void'(sb.pop_front());
    for (int c = 0; c < 3; c++) begin
      drive4(1'b1, 1'b1, 0, 4'hF);
      e = sb.pop_front();
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== e || dout_ch !== 2'((c + 2) % 4) || scan_wrap !== (c == 1)) begin
        n_fail++;
        $display("FAIL mode_switch[%0d]: got %h, want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, e;
    for (int c = 0; c < 40; c++) begin
      din = $urandom;
      drive4(1'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
             4'($urandom));
      e = sb.pop_front();
      obs = {dout, dout_ch, dout_valid, scan_wrap, sel_err};
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h, want %h", c, obs, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t obs, e;
    exp_t want[6];
    int   s_tab[6] = '{1, 3, 0, 0, 0, 0};
    bit   m_tab[6] = '{0, 0, 0, 1, 1, 1};
    want[0] = {8'h02, 2'd1, 1'b1, 1'b0, 1'b0};
    want[1] = {8'h00, 2'd1, 1'b0, 1'b0, 1'b1};
    want[2] = {8'h01, 2'd0, 1'b1, 1'b0, 1'b0};
    want[3] = {8'h02, 2'd1, 1'b1, 1'b0, 1'b0};
    want[4] = {8'h03, 2'd2, 1'b1, 1'b1, 1'b0};
    want[5] = {8'h01, 2'd0, 1'b1, 1'b0, 1'b0};
    din3 = 12'h321;
    for (int c = 0; c < 6; c++) begin
      drive3(m_tab[c], 1'b1, s_tab[c], 3'b111);
      e = sb3.pop_front();
      obs = {4'h0, dout3, dout_ch3, valid3, wrap3, err3};
      n_tests++;
      if (obs !== e || obs !== want[c]) begin
        n_fail++;
        $display("FAIL nch3[%0d]: got %h, want %h", c, obs, want[c]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0; sel = '0; mode = 1'b0; en = 1'b0; mask = '0;
    din3 = '0; sel3 = '0; mode3 = 1'b0; en3 = 1'b0; mask3 = '0;
    reset_model();
    test_reset();
    test_async_reset();
    test_manual();
    test_full_scan();
    test_masked_scan();
    test_mode_switch();
    test_back_to_back();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
